// File: rtl/st7735_pkg.sv
// -----------------------------------------------------------------------------
// st7735_pkg
//
// Shared definitions for the ST7735R-compatible command sequencer:
//   - command opcode constants recognised by the sequencer
//   - sequencer state enum (also exported on the debug state port)
//   - parameter-collection target enum (which register a PARAM phase feeds)
// -----------------------------------------------------------------------------
package st7735_pkg;

  // Supported command opcodes.
  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;

  // Sequencer states. ST_IDLE is the all-zero encoding so the debug state
  // output reads 0 out of reset like every other output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PARAM  = 3'd1,
    ST_PIX_HI = 3'd2,
    ST_PIX_LO = 3'd3,
    ST_SKIP   = 3'd4
  } state_e;

  // Register fed by the parameter bytes currently being collected.
  typedef enum logic [1:0] {
    TGT_CASET  = 2'd0,
    TGT_RASET  = 2'd1,
    TGT_MADCTL = 2'd2
  } tgt_e;

endpackage

// File: rtl/st7735_addr_cursor.sv
// -----------------------------------------------------------------------------
// st7735_addr_cursor
//
// Holds the column/row address window (XS, XE, YS, YE) and the pixel cursor.
// Window updates are atomic: a full 16-bit start/end pair is presented in one
// cycle together with col_set_i or row_set_i, and is clamped to the panel.
//
// Ports:
//   clk_i          : clock (i_spi_clk domain)
//   rst_ni         : asynchronous active-low reset
//   win_rst_i      : restore window and cursor to reset values (SWRESET)
//   load_i         : cursor <= (XS, YS) (start of RAMWR)
//   advance_i      : step cursor one pixel through the window, with wrap
//   col_set_i      : load XS/XE from start_i/end_i (clamped to H_RES-1)
//   row_set_i      : load YS/YE from start_i/end_i (clamped to V_RES-1)
//   start_i/end_i  : 16-bit start/end address as received on the wire
//   x_o / y_o      : current cursor
//   window_valid_o : XS <= XE and YS <= YE
// -----------------------------------------------------------------------------
module st7735_addr_cursor #(
  parameter int H_RES = 480,
  parameter int V_RES = 272,
  parameter int X_W   = 9,
  parameter int Y_W   = 9
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           win_rst_i,
  input  logic           load_i,
  input  logic           advance_i,
  input  logic           col_set_i,
  input  logic           row_set_i,
  input  logic [15:0]    start_i,
  input  logic [15:0]    end_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           window_valid_o
);

  localparam logic [15:0]    X_MAX16 = 16'(H_RES - 1);
  localparam logic [15:0]    Y_MAX16 = 16'(V_RES - 1);
  localparam logic [X_W-1:0] X_MAX   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(V_RES - 1);

  function automatic logic [X_W-1:0] clamp_x(input logic [15:0] v);
    if (v > X_MAX16) return X_MAX;
    else             return v[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [15:0] v);
    if (v > Y_MAX16) return Y_MAX;
    else             return v[Y_W-1:0];
  endfunction

  logic [X_W-1:0] xs_q, xe_q, x_q, x_d;
  logic [Y_W-1:0] ys_q, ye_q, y_q, y_d;

  // Window registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xs_q <= '0;
      xe_q <= X_MAX;
      ys_q <= '0;
      ye_q <= Y_MAX;
    end else if (win_rst_i) begin
      xs_q <= '0;
      xe_q <= X_MAX;
      ys_q <= '0;
      ye_q <= Y_MAX;
    end else begin
      if (col_set_i) begin
        xs_q <= clamp_x(start_i);
        xe_q <= clamp_x(end_i);
      end
      if (row_set_i) begin
        ys_q <= clamp_y(start_i);
        ye_q <= clamp_y(end_i);
      end
    end
  end

  // Cursor next state: raster order inside the window, wrapping to (XS, YS)
  // after the bottom-right corner.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (win_rst_i) begin
      x_d = '0;
      y_d = '0;
    end else if (load_i) begin
      x_d = xs_q;
      y_d = ys_q;
    end else if (advance_i) begin
      if (x_q != xe_q) begin
        x_d = x_q + X_W'(1);
      end else begin
        x_d = xs_q;
        if (y_q != ye_q) y_d = y_q + Y_W'(1);
        else             y_d = ys_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o            = x_q;
  assign y_o            = y_q;
  assign window_valid_o = (xs_q <= xe_q) && (ys_q <= ye_q);

endmodule

// File: rtl/st7735_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// st7735_cmd_sequencer
//
// Decodes the command/parameter byte stream from the SPI deserializer,
// maintains the CASET/RASET window (via st7735_addr_cursor), turns RAMWR
// data into addressed RGB565 pixel writes and holds MADCTL / display-on.
//
// Handshake: i_byte_vld is a one-cycle strobe with no back-pressure; a byte
// is consumed on every rising edge of i_spi_clk where i_byte_vld is high, so
// back-to-back strobes are accepted. o_wr_en is a one-cycle strobe with no
// ready; o_wr_tgl flips with each write for crossing into another clock.
//
// Ports:
//   i_spi_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_byte_vld, i_byte, i_dc: received byte strobe, byte, 0=command 1=data
//   o_wr_en, o_wr_tgl       : pixel write strobe / per-write toggle
//   o_wr_x, o_wr_y          : pixel address (held until next write)
//   o_wr_data               : RGB565 pixel, first byte in [15:8]
//   o_madctl, o_disp_on     : display configuration
//   o_cmd_err               : one-cycle pulse on an unsupported command
//   o_dbg_state             : current sequencer state (state_e encoding)
// -----------------------------------------------------------------------------
module st7735_cmd_sequencer
  import st7735_pkg::*;
#(
  parameter int H_RES = 480,
  parameter int V_RES = 272,
  parameter int X_W   = 9,
  parameter int Y_W   = 9
) (
  input  logic           i_spi_clk,
  input  logic           i_rst_n,
  input  logic           i_byte_vld,
  input  logic [7:0]     i_byte,
  input  logic           i_dc,
  output logic           o_wr_en,
  output logic           o_wr_tgl,
  output logic [X_W-1:0] o_wr_x,
  output logic [Y_W-1:0] o_wr_y,
  output logic [15:0]    o_wr_data,
  output logic [7:0]     o_madctl,
  output logic           o_disp_on,
  output logic           o_cmd_err,
  output logic [2:0]     o_dbg_state
);

  state_e     state_q;
  tgt_e       tgt_q;
  logic [1:0] cnt_q;
  logic [7:0] p0_q, p1_q, p2_q;
  logic [7:0] hi_q;

  logic           is_cmd, is_dat;
  logic           win_rst_c, load_c, col_set_c, row_set_c, advance_c;
  logic           last_param_c;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           win_valid;

  assign is_cmd = i_byte_vld && !i_dc;
  assign is_dat = i_byte_vld &&  i_dc;

  // Cursor/window controls are decoded from the byte being accepted so the
  // sub-module registers update on the same edge as the sequencer state.
  assign last_param_c = is_dat && (state_q == ST_PARAM) && (cnt_q == 2'd3);
  assign win_rst_c    = is_cmd && (i_byte == CMD_SWRESET);
  assign load_c       = is_cmd && (i_byte == CMD_RAMWR);
  assign col_set_c    = last_param_c && (tgt_q == TGT_CASET);
  assign row_set_c    = last_param_c && (tgt_q == TGT_RASET);
  // With an invalid window the pixel is swallowed and the cursor holds.
  assign advance_c    = is_dat && (state_q == ST_PIX_LO) && win_valid;

  st7735_addr_cursor #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_cursor (
    .clk_i          (i_spi_clk),
    .rst_ni         (i_rst_n),
    .win_rst_i      (win_rst_c),
    .load_i         (load_c),
    .advance_i      (advance_c),
    .col_set_i      (col_set_c),
    .row_set_i      (row_set_c),
    .start_i        ({p0_q, p1_q}),
    .end_i          ({p2_q, i_byte}),
    .x_o            (cur_x),
    .y_o            (cur_y),
    .window_valid_o (win_valid)
  );

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      tgt_q     <= TGT_CASET;
      cnt_q     <= '0;
      p0_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      hi_q      <= '0;
      o_wr_en   <= 1'b0;
      o_wr_tgl  <= 1'b0;
      o_wr_x    <= '0;
      o_wr_y    <= '0;
      o_wr_data <= '0;
      o_madctl  <= '0;
      o_disp_on <= 1'b0;
      o_cmd_err <= 1'b0;
    end else begin
      o_wr_en   <= 1'b0;
      o_cmd_err <= 1'b0;
      if (is_cmd) begin
        // A command always abandons partial parameters or a half pixel.
        cnt_q <= '0;
        case (i_byte)
          CMD_NOP, CMD_SLPOUT: state_q <= ST_IDLE;
          CMD_SWRESET: begin
            state_q   <= ST_IDLE;
            o_madctl  <= '0;
            o_disp_on <= 1'b0;
          end
          CMD_DISPOFF: begin
            state_q   <= ST_IDLE;
            o_disp_on <= 1'b0;
          end
          CMD_DISPON: begin
            state_q   <= ST_IDLE;
            o_disp_on <= 1'b1;
          end
          CMD_CASET: begin
            state_q <= ST_PARAM;
            tgt_q   <= TGT_CASET;
          end
          CMD_RASET: begin
            state_q <= ST_PARAM;
            tgt_q   <= TGT_RASET;
          end
          CMD_MADCTL: begin
            state_q <= ST_PARAM;
            tgt_q   <= TGT_MADCTL;
          end
          CMD_RAMWR: state_q <= ST_PIX_HI;
          default: begin
            state_q   <= ST_SKIP;
            o_cmd_err <= 1'b1;
          end
        endcase
      end else if (is_dat) begin
        case (state_q)
          ST_PARAM: begin
            if (tgt_q == TGT_MADCTL) begin
              o_madctl <= i_byte;
              state_q  <= ST_IDLE;
            end else begin
              case (cnt_q)
                2'd0:    p0_q <= i_byte;
                2'd1:    p1_q <= i_byte;
                2'd2:    p2_q <= i_byte;
                default: state_q <= ST_IDLE;  // 4th byte: window loads now
              endcase
              cnt_q <= cnt_q + 2'd1;
            end
          end
          ST_PIX_HI: begin
            hi_q    <= i_byte;
            state_q <= ST_PIX_LO;
          end
          ST_PIX_LO: begin
            if (win_valid) begin
              o_wr_en   <= 1'b1;
              o_wr_tgl  <= ~o_wr_tgl;
              o_wr_x    <= cur_x;
              o_wr_y    <= cur_y;
              o_wr_data <= {hi_q, i_byte};
            end
            state_q <= ST_PIX_HI;
          end
          default: ;  // IDLE and SKIP discard data bytes
        endcase
      end
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: doc/st7735_cmd_sequencer.md
# st7735_cmd_sequencer

Byte-level command sequencer for the ST7735R-compatible SPI display path. It sits directly after the SPI byte deserializer in the `i_spi_clk` domain and decodes command and parameter bytes. It maintains the column/row address window set by CASET/RASET and turns the RAMWR byte stream into addressed 16-bit pixel writes for the frame buffer. It also holds the display configuration registers (MADCTL, display on/off) for the video timing block.

## Interface
- `H_RES`, 480: horizontal panel resolution in pixels.
- `V_RES`, 272: vertical panel resolution in lines.
- `X_W`, 9: width of the column address and cursor.
- `Y_W`, 9: width of the row address and cursor.

Ports:
- `i_spi_clk`  in  1: clock. Bytes are processed on its rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_byte_vld`  in  1: one-cycle strobe marking a complete received byte.
- `i_byte`  in  8: received byte, MSB first on the wire. Valid with `i_byte_vld`.
- `i_dc`  in  1: qualifies `i_byte`. 0 = command, 1 = data/parameter.
- `o_wr_en`  out  1: one-cycle pixel write strobe.
- `o_wr_tgl`  out  1: flips once per pixel write, for CDC into `i_clk`.
- `o_wr_x`  out  X_W: column address of the current pixel.
- `o_wr_y`  out  Y_W: row address of the current pixel.
- `o_wr_data`  out  16: RGB565 pixel value, first byte in [15:8].
- `o_madctl`  out  8: last MADCTL parameter.
- `o_disp_on`  out  1: display enable.
- `o_cmd_err`  out  1: one-cycle pulse when an unsupported command is received.

## Operation
- **Reset values:** all outputs 0, except `o_madctl`=0x00.
- **Window reset values:** XS=0, XE=H_RES-1, YS=0, YE=V_RES-1. Cursor = (0,0). State IDLE.
- **Byte classification:**
  - A byte with `i_dc`=0 is a command.
  - A command always aborts any sequence in progress, including a half-collected pixel or partial parameters, then decodes.
- **Supported commands:**
  - 0x00 NOP: no action.
  - 0x11 SLPOUT: no action.
  - 0x01 SWRESET: restores window, cursor, `o_madctl` and `o_disp_on` to reset values. `o_wr_tgl` is kept.
  - 0x28 DISPOFF: clears `o_disp_on`.
  - 0x29 DISPON: sets `o_disp_on`.
  - 0x2A CASET: collects 4 parameters.
  - 0x2B RASET: collects 4 parameters.
  - 0x36 MADCTL: collects 1 parameter.
  - 0x2C RAMWR: starts the pixel stream.
- Any other command pulses `o_cmd_err` and enters SKIP, which discards data bytes until the next command.
- **State machine:** IDLE, PARAM (2-bit counter plus target select CASET/RASET/MADCTL), PIX_HI, PIX_LO, SKIP.
- **CASET/RASET parameters:**
  - Byte order: S[15:8], S[7:0], E[15:8], E[7:0].
  - The window is updated atomically on the 4th byte only. Partial sequences have no effect.
  - Values above H_RES-1 (or V_RES-1) are clamped to that maximum.
  - Data bytes after the 4th are ignored; state returns to IDLE.
- **MADCTL:** the 1st data byte is latched into `o_madctl`. Further data bytes are ignored.
- **RAMWR:**
  - On the command, cursor is set to (XS,YS) and state goes to PIX_HI.
  - PIX_HI stores the byte as the high byte.
  - PIX_LO emits a pixel {hi,lo} at the cursor, then advances the cursor.
- **Cursor advance:**
  - If x≠XE: x+1.
  - Else x=XS and y advances: if y≠YE then y+1, else y=YS (window wrap).
- **Invalid window:** if XS>XE or YS>YE, RAMWR bytes are consumed but `o_wr_en` never asserts and the cursor holds.
- **Data in IDLE:** data bytes received in IDLE are ignored.

## Timing
- Pixel write latency: `o_wr_en`, `o_wr_x/y` and `o_wr_data` are registered. They are valid on the `i_spi_clk` edge after the edge sampling the low byte's `i_byte_vld`, and `o_wr_en` lasts exactly one `i_spi_clk` cycle.
- `o_wr_tgl` flips in the same cycle that `o_wr_en` asserts.
- `i_spi_clk` may stop after the last byte, so the `i_clk` domain must use `o_wr_tgl` (2-FF sync, edge detect), not `o_wr_en`.
- `o_wr_x/y/data` hold until the next write.
- Throughput: one byte per `i_spi_clk` cycle at most. Back-to-back `i_byte_vld` must be supported.
- Config outputs update 1 cycle after the final parameter or command byte.
- `o_cmd_err` asserts 1 cycle after the command byte.
- Reset mid-RAMWR: asynchronous return to reset values. No write is emitted for the pending high byte.

## Structure
- Package `st7735_pkg`: command opcode constants (CMD_NOP, CMD_SWRESET, CMD_SLPOUT, CMD_DISPOFF, CMD_DISPON, CMD_CASET, CMD_RASET, CMD_RAMWR, CMD_MADCTL) and the state enum.
- Sub-module `st7735_addr_cursor` holds the window registers and the cursor. Interface:
  - Inputs: load, advance, window set.
  - Outputs: x, y, window_valid.

## Test plan
- **CASET + RASET + RAMWR:** CASET 0,2,0,3; RASET 0,5,0,6; RAMWR; 8 pixels 0x1234..0x123B.
  - Writes at (2,5),(3,5),(2,6),(3,6), then wrap to (2,5).
  - Data order intact; `o_wr_tgl` toggles 8 times.
- **Clamp and invalid window:**
  - CASET 0x01,0xF4 for XS: XS clamps to 479.
  - CASET with XS=10, XE=4 followed by RAMWR with 4 bytes: zero `o_wr_en`.
- **Abort:**
  - RAMWR with 1 data byte, then 0x29: no write, `o_disp_on`=1.
  - CASET with 2 params, then NOP: window unchanged.
- **Unknown command:** 0xB1 with 3 data bytes, then RAMWR 0xF8,0x00.
  - One `o_cmd_err` pulse.
  - Pixel 0xF800 written at (XS,YS).
- **Resets:**
  - MADCTL 0xC0, DISPON, then SWRESET: `o_madctl`=0, `o_disp_on`=0, window reset.
  - `i_rst_n` low mid-stream: all outputs 0 asynchronously.
